// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one fixed-latency memory port
//            between the CPU datapath and the character I/O engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_io_q, owner_io_d;
  logic                last_io_q, last_io_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                io_ready_q, io_ready_d;
  logic                busy_q, busy_d;
  logic                grant_io;
  logic                grant_we;

  always_comb begin
    state_d     = state_q;
    owner_io_d  = owner_io_q;
    last_io_d   = last_io_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    cpu_ready_d = 1'b0;
    io_ready_d  = 1'b0;
    busy_d      = busy_q;
    // IO wins only when alone or when the CPU was served last.
    grant_io    = io_req & (~cpu_req | ~last_io_q);
    grant_we    = grant_io ? io_we : cpu_we;

    case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          state_d     = ACCESS;
          owner_io_d  = grant_io;
          last_io_d   = grant_io;
          cnt_d       = CNT_LOAD;
          mem_addr_d  = grant_io ? io_addr  : cpu_addr;
          mem_wdata_d = grant_io ? io_wdata : cpu_wdata;
          mem_re_d    = ~grant_we;
          mem_we_d    = grant_we;
          busy_d      = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!mem_we_q) begin
            if (owner_io_q) io_rdata_d  = mem_rdata;
            else            cpu_rdata_d = mem_rdata;
          end
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = ~owner_io_q;
          io_ready_d  = owner_io_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_io_q  <= 1'b0;
      last_io_q   <= 1'b1;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
      cpu_ready_q <= 1'b0;
      io_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_io_q  <= owner_io_d;
      last_io_q   <= last_io_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      io_ready_q  <= io_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign io_ready  = io_ready_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter at MEM_LAT = 1, 2 and 3.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata, mem_rdata;

  // Index g of each output array belongs to the instance with MEM_LAT = g.
  logic [31:0] cpu_rdata [1:3];
  logic [31:0] io_rdata  [1:3];
  logic [31:0] mem_addr  [1:3];
  logic [31:0] mem_wdata [1:3];
  logic        cpu_ready [1:3];
  logic        io_ready  [1:3];
  logic        mem_re    [1:3];
  logic        mem_we    [1:3];
  logic        busy      [1:3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .io_req    (io_req),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata[g]),
      .io_ready  (io_ready[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_re    (mem_re[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata),
      .busy      (busy[g])
    );
  end

  typedef struct {
    logic        rst, creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        ireq, iwe;
    logic [31:0] iaddr, iwdata, mrdata;
    logic        re, we;
    logic [31:0] maddr, mwdata;
    logic        crdy, irdy, bsy;
    logic [31:0] crdata, irdata;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(
    logic rst, logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwdata,
    logic ireq, logic iwe, logic [31:0] iaddr, logic [31:0] iwdata, logic [31:0] mrdata,
    logic re, logic we, logic [31:0] maddr, logic [31:0] mwdata,
    logic crdy, logic irdy, logic bsy, logic [31:0] crdata, logic [31:0] irdata);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.ireq = ireq; v.iwe = iwe; v.iaddr = iaddr; v.iwdata = iwdata; v.mrdata = mrdata;
    v.re = re; v.we = we; v.maddr = maddr; v.mwdata = mwdata;
    v.crdy = crdy; v.irdy = irdy; v.bsy = bsy; v.crdata = crdata; v.irdata = irdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req  = 0; io_we  = 0; io_addr  = 0; io_wdata  = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  localparam logic [31:0] CA = 32'h20, CW = 32'h11, IA = 32'h30, IW = 32'h22;
  localparam logic [31:0] MR = 32'h5555AAAA, DB = 32'hDEADBEEF;

  initial begin
    // Rows: inputs driven in that cycle, outputs expected from MEM_LAT=1 in that cycle.
    //             rst c  cw caddr  cwd ir iw iaddr iwd  mrd   re we maddr  mwd cr ir by crd irdat
    vt[0]  = mk(0, 1, 0, 32'h10, 0,  0, 0, 0,  0,  DB,   0, 0, 0,     0,  0, 0, 0, 0,  0);
    vt[1]  = mk(0, 1, 0, 32'h10, 0,  0, 0, 0,  0,  DB,   1, 0, 32'h10, 0, 0, 0, 1, 0,  0);
    vt[2]  = mk(0, 1, 0, 32'h10, 0,  0, 0, 0,  0,  DB,   0, 0, 32'h10, 0, 1, 0, 1, DB, 0);
    vt[3]  = mk(0, 0, 0, 0,      0,  0, 0, 0,  0,  DB,   0, 0, 32'h10, 0, 0, 0, 0, DB, 0);
    vt[4]  = mk(1, 0, 0, 0,      0,  0, 0, 0,  0,  DB,   0, 0, 32'h10, 0, 0, 0, 0, DB, 0);
    vt[5]  = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, 0,     0,  0, 0, 0, 0,  0);
    vt[6]  = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 1, CA,    CW, 0, 0, 1, 0,  0);
    vt[7]  = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, CA,    CW, 1, 0, 1, 0,  0);
    vt[8]  = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, CA,    CW, 0, 0, 0, 0,  0);
    vt[9]  = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   1, 0, IA,    IW, 0, 0, 1, 0,  0);
    vt[10] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, IA,    IW, 0, 1, 1, 0,  MR);
    vt[11] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, IA,    IW, 0, 0, 0, 0,  MR);
    vt[12] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 1, CA,    CW, 0, 0, 1, 0,  MR);
    vt[13] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, CA,    CW, 1, 0, 1, 0,  MR);
    vt[14] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, CA,    CW, 0, 0, 0, 0,  MR);
    vt[15] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   1, 0, IA,    IW, 0, 0, 1, 0,  MR);
    vt[16] = mk(0, 1, 1, CA,     CW, 1, 0, IA, IW, MR,   0, 0, IA,    IW, 0, 1, 1, 0,  MR);
    vt[17] = mk(0, 0, 0, 0,      0,  0, 0, 0,  0,  MR,   0, 0, IA,    IW, 0, 0, 0, 0,  MR);

    mem_rdata = 0;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d mem_re", i),    {31'd0, mem_re[1]},    {31'd0, vt[i].re});
      chk($sformatf("v%0d mem_we", i),    {31'd0, mem_we[1]},    {31'd0, vt[i].we});
      chk($sformatf("v%0d mem_addr", i),  mem_addr[1],           vt[i].maddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata[1],          vt[i].mwdata);
      chk($sformatf("v%0d cpu_ready", i), {31'd0, cpu_ready[1]}, {31'd0, vt[i].crdy});
      chk($sformatf("v%0d io_ready", i),  {31'd0, io_ready[1]},  {31'd0, vt[i].irdy});
      chk($sformatf("v%0d busy", i),      {31'd0, busy[1]},      {31'd0, vt[i].bsy});
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata[1],          vt[i].crdata);
      chk($sformatf("v%0d io_rdata", i),  io_rdata[1],           vt[i].irdata);
      reset = vt[i].rst;
      cpu_req = vt[i].creq; cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwdata;
      io_req  = vt[i].ireq; io_we  = vt[i].iwe; io_addr  = vt[i].iaddr; io_wdata  = vt[i].iwdata;
      mem_rdata = vt[i].mrdata;
      tick();
    end

    // IO write with MEM_LAT=3: enables held for cycles 1-3, ready in cycle 4.
    do_reset();
    io_req = 1; io_we = 1; io_addr = 32'h200; io_wdata = 32'h41;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) io_req = 0;
      chk($sformatf("iow c%0d mem_we", c),   {31'd0, mem_we[3]},   (c <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("iow c%0d mem_re", c),   {31'd0, mem_re[3]},   32'd0);
      chk($sformatf("iow c%0d io_ready", c), {31'd0, io_ready[3]}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("iow c%0d cpu_ready", c), {31'd0, cpu_ready[3]}, 32'd0);
      if (c <= 3) begin
        chk($sformatf("iow c%0d mem_addr", c),  mem_addr[3],  32'h200);
        chk($sformatf("iow c%0d mem_wdata", c), mem_wdata[3], 32'h41);
      end
    end

    // Address change mid-access with MEM_LAT=2 must not reach the memory port.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'h12345678;
    tick();
    cpu_addr = 32'h99;
    chk("chg c1 mem_addr", mem_addr[2], 32'h10);
    chk("chg c1 mem_re", {31'd0, mem_re[2]}, 32'd1);
    tick();
    chk("chg c2 mem_addr", mem_addr[2], 32'h10);
    chk("chg c2 mem_re", {31'd0, mem_re[2]}, 32'd1);
    tick();
    chk("chg c3 cpu_ready", {31'd0, cpu_ready[2]}, 32'd1);
    chk("chg c3 cpu_rdata", cpu_rdata[2], 32'h12345678);
    cpu_req = 0;

    // Reset during a MEM_LAT=3 IO write aborts it; CPU then wins the tie.
    do_reset();
    io_req = 1; io_we = 1; io_addr = 32'h200; io_wdata = 32'h41;
    tick();
    chk("rst c1 mem_we", {31'd0, mem_we[3]}, 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst c2 mem_we", {31'd0, mem_we[3]}, 32'd0);
    chk("rst c2 busy", {31'd0, busy[3]}, 32'd0);
    chk("rst c2 io_ready", {31'd0, io_ready[3]}, 32'd0);
    chk("rst c2 mem_addr", mem_addr[3], 32'd0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    tick();
    chk("rst c3 mem_addr", mem_addr[3], 32'h10);
    chk("rst c3 mem_re", {31'd0, mem_re[3]}, 32'd1);
    chk("rst c3 mem_we", {31'd0, mem_we[3]}, 32'd0);
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk($sformatf("rst c%0d io_ready", c), {31'd0, io_ready[3]}, 32'd0);
      chk($sformatf("rst c%0d cpu_ready", c), {31'd0, cpu_ready[3]}, (c == 6) ? 32'd1 : 32'd0);
    end
    idle_inputs();

    // Idle stability on all three latencies.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int g = 1; g <= 3; g++)
        chk($sformatf("idle c%0d lat%0d", c, g),
            {27'd0, busy[g], mem_re[g], mem_we[g], cpu_ready[g], io_ready[g]}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: the multicycle CPU datapath (instruction fetch and lw/sw traffic) and the character I/O engine, which stores incoming characters and reads display data.
- Round-robin arbitration between the two requesters.
- Fixed-latency memory access sequencing.
- A req/ready handshake per requester.
- Sits between the CPU control/datapath, the I/O engine and the memory block.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LAT, 1, number of cycles mem_re/mem_we are held per access; legal range is MEM_LAT >= 1.

Ports:
- clk  in  1  system clock; all logic uses the rising edge.
- reset  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- io_req  in  1  I/O access request.
- io_we  in  1  1 = write, 0 = read.
- io_addr  in  ADDR_W  I/O address.
- io_wdata  in  DATA_W  I/O write data.
- io_rdata  out  DATA_W  I/O read data; valid while io_ready=1.
- io_ready  out  1  one-cycle completion pulse to the I/O engine.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, last_grant=IO (so the CPU wins the first tie), wait counter=0. All outputs are 0: mem_addr, mem_wdata, mem_re, mem_we, cpu_rdata, io_rdata, cpu_ready, io_ready, busy.
- All outputs are registered.
- States: IDLE, ACCESS, DONE.
- IDLE: requests are sampled here.
  - Only cpu_req=1: grant CPU.
  - Only io_req=1: grant IO.
  - Both set: grant the requester that is not last_grant.
  - Neither set: stay in IDLE.
  - On grant, at the next edge: latch owner, load mem_addr, mem_wdata and the we bit from the owner, set mem_re=~we and mem_we=we, set counter=MEM_LAT-1, update last_grant=owner, go to ACCESS.
- ACCESS: mem_addr, mem_wdata, mem_re and mem_we are held constant.
  - counter>0: decrement counter and stay in ACCESS.
  - counter==0: capture mem_rdata into the owner's rdata register (reads only; on a write the rdata register keeps its previous value). Clear mem_re and mem_we, pulse the owner's ready, go to DONE.
- DONE: lasts exactly 1 cycle, and the owner's ready=1 throughout it.
  - Requests are ignored in DONE.
  - Next state is IDLE, and ready returns to 0.
- Latency: request sampled in IDLE at cycle 0 → mem enables high for cycles 1..MEM_LAT → ready=1 in cycle MEM_LAT+1. Back-to-back accesses cost MEM_LAT+2 cycles each.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable from assertion until it samples ready=1.
  - It deasserts req (or presents a new request) on that same edge.
  - Requester inputs that change during ACCESS are ignored, because the access values are latched.
- Losing requester: it keeps req high and is served in the next IDLE.
  - Round-robin bounds the wait to one access, i.e. MEM_LAT+2 cycles.
- Non-owner ready remains 0 at all times.
- Only one of mem_re and mem_we is ever high.
- busy = (state != IDLE).
- Reset asserted mid-ACCESS or mid-DONE:
  - The access is aborted, with no ready pulse.
  - All outputs are 0 from the next cycle.
  - last_grant returns to IO.
- A write that is aborted mid-access may have partially committed; the requester must reissue it.

Test Plan:
- CPU read, MEM_LAT=1: cpu_req=1, cpu_we=0, addr=0x10 in cycle 0, memory returns 0xDEADBEEF. Required: mem_re=1 and mem_addr=0x10 in cycle 1; cpu_ready=1 and cpu_rdata=0xDEADBEEF in cycle 2; io_ready=0 throughout.
- IO write, MEM_LAT=3: io_req=1, io_we=1, addr=0x200, wdata=0x41. Required: mem_we=1 with addr=0x200 and wdata=0x41 for exactly cycles 1-3; io_ready=1 in cycle 4; mem_re=0 throughout.
- Simultaneous requests after reset: cpu_req and io_req both held high continuously. Required grant order CPU, IO, CPU, IO; with MEM_LAT=1 the ready pulses land in cycles 2, 5, 8, 11.
- Input change during access: cpu_addr changes 0x10→0x99 in cycle 1 of a MEM_LAT=2 read. Required: mem_addr stays 0x10 for cycles 1-2.
- Reset during access: reset=1 in cycle 1 of a MEM_LAT=3 IO write. Required: mem_we=0 and busy=0 from cycle 2, no io_ready pulse, and the next simultaneous request is granted to the CPU.
- Idle stability: no requests for 20 cycles. Required: busy, mem_re, mem_we and both ready outputs stay 0 throughout.
